lsu: RTL

- Load/store stage directly downstream of the execute unit.
- Consumes the execute unit's ALU result (effective address), rs2 value (store data), func3 and rd.
- Runs a valid/ready request/response transaction with data memory.
- Aligns and extends load data, then returns a one-cycle register-writeback pulse to the decode/regfile side; stalls upstream while busy.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_align.sv | 49 ++++
 rtl/lsu.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, RV32 func3 width codes
// and byte-strobe patterns.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] STRB_NONE = 4'b0000;
  localparam logic [3:0] STRB_B    = 4'b0001;
  localparam logic [3:0] STRB_H    = 4'b0011;
  localparam logic [3:0] STRB_W    = 4'b1111;

  // func3[1:0] encodes access size for both loads and stores (01 = half, 10 = word).
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract/extend and store strobe/replication.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            addr_lo,
  input  logic [2:0]            func3,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] load_val,
  output logic [3:0]            wstrb,
  output logic [DATA_WIDTH-1:0] store_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];

    load_val = '0;
    case (func3)
      F3_LB:   load_val = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  load_val = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      F3_LH:   load_val = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      F3_LHU:  load_val = {{(DATA_WIDTH-16){1'b0}}, half_sel};
      F3_LW:   load_val = rdata;
      default: load_val = '0;
    endcase

    wstrb      = STRB_NONE;
    store_data = wdata;
    case (func3)
      F3_SB: begin
        wstrb      = STRB_B << addr_lo;
        store_data = {(DATA_WIDTH/8){wdata[7:0]}};
      end
      F3_SH: begin
        wstrb      = STRB_H << {addr_lo[1], 1'b0};
        store_data = {(DATA_WIDTH/16){wdata[15:0]}};
      end
      F3_SW:   wstrb = STRB_W;
      default: wstrb = STRB_NONE;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store stage: one outstanding data-memory access, registered writeback pulse.
// Optional LSU_MISALIGN_CHECK_EN rejects misaligned half/word accesses at accept.
module lsu
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      is_load_i,
  input  logic                      is_store_i,
  input  logic [2:0]                func3_i,
  input  logic [ADDR_WIDTH-1:0]     addr_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_i,
  output logic                      dmem_req_valid_o,
  input  logic                      dmem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]     dmem_addr_o,
  output logic                      dmem_wen_o,
  output logic [3:0]                dmem_wstrb_o,
  output logic [DATA_WIDTH-1:0]     dmem_wdata_o,
  input  logic                      dmem_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0]     dmem_rdata_i,
  output logic [DATA_WIDTH-1:0]     wrtbck_val_idu_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_idu_o,
  output logic                      wrtbck_en_idu_o,
  output logic                      lsu_busy_o,
  output logic                      lsu_err_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [2:0]                func3_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic                      is_load_q;
  logic [CNT_W-1:0]          cnt_q;

  logic [DATA_WIDTH-1:0]     wb_val_q;
  logic [REG_ADDR_WIDTH-1:0] wb_rd_q;
  logic                      wb_en_q;
  logic                      err_q;

  logic                      accept, reject, rsp_done, timeout, handshake, misalign;
  logic [DATA_WIDTH-1:0]     load_val, store_data;
  logic [3:0]                wstrb;

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign = is_misaligned(func3_i, addr_i[1:0]);
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    reject    = 1'b0;
    handshake = 1'b0;
    rsp_done  = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i && (is_load_i || is_store_i)) begin
          if (misalign) begin
            reject = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (dmem_req_ready_i) begin
          handshake = 1'b1;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (dmem_rsp_valid_i) begin
          rsp_done = 1'b1;
          state_d  = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      func3_q   <= '0;
      rd_q      <= '0;
      is_load_q <= 1'b0;
      cnt_q     <= '0;
      wb_val_q  <= '0;
      wb_rd_q   <= '0;
      wb_en_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wb_en_q <= 1'b0;
      err_q   <= reject | timeout;
      if (accept) begin
        addr_q    <= addr_i;
        wdata_q   <= wdata_i;
        func3_q   <= func3_i;
        rd_q      <= rd_i;
        is_load_q <= is_load_i;  // load wins when both flags are set
      end
      if (handshake) cnt_q <= '0;
      else if (state_q == ST_WAIT && !dmem_rsp_valid_i) cnt_q <= cnt_q + 1'b1;
      if (rsp_done && is_load_q) begin
        wb_en_q  <= (rd_q != '0);
        wb_val_q <= load_val;
        wb_rd_q  <= rd_q;
      end
    end
  end

  lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .rdata      (dmem_rdata_i),
    .addr_lo    (addr_q[1:0]),
    .func3      (func3_q),
    .wdata      (wdata_q),
    .load_val   (load_val),
    .wstrb      (wstrb),
    .store_data (store_data)
  );

  // Write-side controls are only meaningful while the request is on the bus.
  assign req_ready_o      = (state_q == ST_IDLE);
  assign lsu_busy_o       = (state_q != ST_IDLE);
  assign dmem_req_valid_o = (state_q == ST_REQ);
  assign dmem_addr_o      = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign dmem_wen_o       = dmem_req_valid_o && !is_load_q;
  assign dmem_wstrb_o     = dmem_wen_o ? wstrb : STRB_NONE;
  assign dmem_wdata_o     = dmem_wen_o ? store_data : '0;
  assign wrtbck_val_idu_o = wb_val_q;
  assign rd_idu_o         = wb_rd_q;
  assign wrtbck_en_idu_o  = wb_en_q;
  assign lsu_err_o        = err_q;

endmodule
